// File: rtl/execute_stage.sv
// execute_stage: execute stage of the rvga pipeline.
// Single-cycle integer ALU plus an iterative shift-add multiplier and
// restoring divider (iter_p cycles) that stalls upstream while busy.
// Ports:
//   clk_i, rst_i (async, active-high), flush_i (sync kill)
//   rfetch_*         : operands/pc/rd from register fetch, rfetch_v_i valid
//   exec_op_i        : 4-bit opcode; exec_a_pc_i / exec_b_imm_i operand selects
//   exec_rd_w_v_i    : instruction writes rd
//   stall_o          : high while the mul/div unit is busy
//   execute_*        : registered valid, pc, rd, rd write enable, result
module execute_stage #(
  parameter int unsigned width_p = 32,
  parameter int unsigned iter_p  = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               rfetch_v_i,
  input  logic [width_p-1:0] rfetch_pc,
  input  logic [4:0]         rfetch_rd,
  input  logic [width_p-1:0] rfetch_rs1_data,
  input  logic [width_p-1:0] rfetch_rs2_data,
  input  logic [width_p-1:0] rfetch_imm_data,
  input  logic [3:0]         exec_op_i,
  input  logic               exec_a_pc_i,
  input  logic               exec_b_imm_i,
  input  logic               exec_rd_w_v_i,
  output logic               stall_o,
  output logic               execute_v_o,
  output logic [width_p-1:0] execute_pc,
  output logic [4:0]         execute_rd,
  output logic               execute_rd_w_v,
  output logic [width_p-1:0] execute_result
);

  localparam int unsigned W     = width_p;
  localparam int unsigned CNT_W = $clog2(iter_p);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(iter_p - 1);

  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd13;
  localparam logic [3:0] OP_REMU = 4'd14;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2*W-1:0]   r_acc;
  logic [W-1:0]     r_b;
  logic [3:0]       r_op;
  logic [W-1:0]     r_pc;
  logic [4:0]       r_rd;
  logic             r_rd_w_v;

  logic [W-1:0]     w_a, w_b, w_alu;
  logic [4:0]       w_shamt;
  logic             w_is_long, w_accept, w_final, w_is_div;
  logic [W:0]       w_mul_sum, w_rem_sh;
  logic             w_div_ge;
  logic [W-1:0]     w_rem_new, w_long_res;
  logic [2*W-1:0]   w_step;

  assign w_a       = exec_a_pc_i  ? rfetch_pc       : rfetch_rs1_data;
  assign w_b       = exec_b_imm_i ? rfetch_imm_data : rfetch_rs2_data;
  assign w_shamt   = w_b[4:0];
  assign w_is_long = (exec_op_i >= 4'd11) && (exec_op_i <= 4'd14);
  assign stall_o   = (r_state == BUSY);
  assign w_accept  = rfetch_v_i && !stall_o && !flush_i;
  assign w_final   = (r_state == BUSY) && (r_cnt == CNT_LAST);
  assign w_is_div  = (r_op == OP_DIVU) || (r_op == OP_REMU);

  always_comb begin
    w_alu = '0;
    case (exec_op_i)
      4'd0:    w_alu = w_a + w_b;
      4'd1:    w_alu = w_a - w_b;
      4'd2:    w_alu = w_a << w_shamt;
      4'd3:    w_alu = {{(W-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      4'd4:    w_alu = {{(W-1){1'b0}}, (w_a < w_b)};
      4'd5:    w_alu = w_a ^ w_b;
      4'd6:    w_alu = w_a >> w_shamt;
      4'd7:    w_alu = W'($signed(w_a) >>> w_shamt);
      4'd8:    w_alu = w_a | w_b;
      4'd9:    w_alu = w_a & w_b;
      4'd10:   w_alu = w_b;
      default: w_alu = '0;
    endcase
  end

  // r_acc is shared: multiply keeps {partial product, remaining multiplier},
  // divide keeps {partial remainder, dividend shifting into quotient}.
  // Both leave the low result in [W-1:0] and the high/remainder in [2W-1:W].
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_rem_sh   = {r_acc[2*W-1:W], r_acc[W-1]};
    w_div_ge   = (w_rem_sh >= {1'b0, r_b});
    w_rem_new  = w_div_ge ? W'(w_rem_sh - {1'b0, r_b}) : w_rem_sh[W-1:0];
    w_step     = w_is_div ? {w_rem_new, r_acc[W-2:0], w_div_ge}
                          : {w_mul_sum, r_acc[W-1:1]};
    w_long_res = ((r_op == OP_MUL) || (r_op == OP_DIVU)) ? w_step[W-1:0]
                                                         : w_step[2*W-1:W];
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (rfetch_v_i && w_is_long && !flush_i) w_state_next = BUSY;
      BUSY:    if (flush_i || w_final) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt          <= '0;
      r_acc          <= '0;
      r_b            <= '0;
      r_op           <= '0;
      r_pc           <= '0;
      r_rd           <= '0;
      r_rd_w_v       <= 1'b0;
      execute_v_o    <= 1'b0;
      execute_pc     <= '0;
      execute_rd     <= '0;
      execute_rd_w_v <= 1'b0;
      execute_result <= '0;
    end else begin
      execute_v_o    <= 1'b0;
      execute_rd_w_v <= 1'b0;
      if (flush_i) begin
        // in-flight work is abandoned; state returns to IDLE via the FSM
      end else if (w_accept && w_is_long) begin
        r_acc    <= {{W{1'b0}}, w_a};
        r_b      <= w_b;
        r_op     <= exec_op_i;
        r_pc     <= rfetch_pc;
        r_rd     <= rfetch_rd;
        r_rd_w_v <= exec_rd_w_v_i;
        r_cnt    <= '0;
      end else if (w_accept) begin
        execute_v_o    <= 1'b1;
        execute_pc     <= rfetch_pc;
        execute_rd     <= rfetch_rd;
        execute_rd_w_v <= exec_rd_w_v_i;
        execute_result <= w_alu;
      end else if (r_state == BUSY) begin
        r_acc <= w_step;
        r_cnt <= r_cnt + 1'b1;
        if (w_final) begin
          execute_v_o    <= 1'b1;
          execute_pc     <= r_pc;
          execute_rd     <= r_rd;
          execute_rd_w_v <= r_rd_w_v;
          execute_result <= w_long_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        rfetch_v_i;
  logic [31:0] rfetch_pc;
  logic [4:0]  rfetch_rd;
  logic [31:0] rfetch_rs1_data;
  logic [31:0] rfetch_rs2_data;
  logic [31:0] rfetch_imm_data;
  logic [3:0]  exec_op_i;
  logic        exec_a_pc_i;
  logic        exec_b_imm_i;
  logic        exec_rd_w_v_i;
  logic        stall_o;
  logic        execute_v_o;
  logic [31:0] execute_pc;
  logic [4:0]  execute_rd;
  logic        execute_rd_w_v;
  logic [31:0] execute_result;

  execute_stage #(.width_p(32), .iter_p(32)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .rfetch_v_i      (rfetch_v_i),
    .rfetch_pc       (rfetch_pc),
    .rfetch_rd       (rfetch_rd),
    .rfetch_rs1_data (rfetch_rs1_data),
    .rfetch_rs2_data (rfetch_rs2_data),
    .rfetch_imm_data (rfetch_imm_data),
    .exec_op_i       (exec_op_i),
    .exec_a_pc_i     (exec_a_pc_i),
    .exec_b_imm_i    (exec_b_imm_i),
    .exec_rd_w_v_i   (exec_rd_w_v_i),
    .stall_o         (stall_o),
    .execute_v_o     (execute_v_o),
    .execute_pc      (execute_pc),
    .execute_rd      (execute_rd),
    .execute_rd_w_v  (execute_rd_w_v),
    .execute_result  (execute_result)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [31:0] result;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rdw;
    int unsigned cyc;
  } out_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        a_pc;
    logic        b_imm;
    logic [31:0] exp;
  } vec_t;

  out_t mon_q[$];
  out_t exp_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i) begin
    out_t m;
    #1;
    if (execute_v_o) begin
      m.result = execute_result;
      m.pc     = execute_pc;
      m.rd     = execute_rd;
      m.rdw    = execute_rd_w_v;
      m.cyc    = cyc;
      mon_q.push_back(m);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference behaviour from the opcode definitions, using plain arithmetic.
  function automatic logic [31:0] ref_result(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    int unsigned sh;
    p  = 64'(a) * 64'(b);
    sh = int'(b % 32);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << sh;
      4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> sh;
      4'd7:  return 32'($signed(a) >>> sh);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      4'd11: return p[31:0];
      4'd12: return p[63:32];
      4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] pc,
                       input logic [4:0] rd, input logic apc, input logic bimm, input logic rdw);
    rfetch_v_i      = v;
    exec_op_i       = op;
    rfetch_rs1_data = rs1;
    rfetch_rs2_data = rs2;
    rfetch_imm_data = imm;
    rfetch_pc       = pc;
    rfetch_rd       = rd;
    exec_a_pc_i     = apc;
    exec_b_imm_i    = bimm;
    exec_rd_w_v_i   = rdw;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Holds the instruction valid until an edge where it was not stalled.
  task automatic present(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd,
                         input logic apc, input logic bimm, input logic rdw);
    logic st;
    bit   done;
    int   n;
    drive(1'b1, op, rs1, rs2, imm, pc, rd, apc, bimm, rdw);
    done = 0;
    n = 0;
    while (!done && n < 100) begin
      st = stall_o;
      @(posedge clk_i);
      #1;
      n++;
      if (!st) done = 1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL present_timeout: got stalled expected accept");
    end
    rfetch_v_i = 1'b0;
  endtask

  task automatic run_long(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    int lat;
    int stall_cnt;
    present(op, a, b, 32'h0, 32'h0000_2000, 5'd7, 1'b0, 1'b0, 1'b1);
    lat = 0;
    stall_cnt = 0;
    while (!execute_v_o && lat < 40) begin
      if (stall_o) stall_cnt++;
      @(posedge clk_i);
      #1;
      lat++;
    end
    check({name, "_latency"}, lat, 32);
    check({name, "_stall_cycles"}, stall_cnt, 32);
    check({name, "_result"}, execute_result, exp);
    check({name, "_pc"}, execute_pc, 32'h0000_2000);
    check({name, "_stall_after"}, {31'b0, stall_o}, 32'd0);
    idle(1);
    check({name, "_single_valid"}, {31'b0, execute_v_o}, 32'd0);
  endtask

  vec_t vecs[15];

  initial begin
    logic [3:0]  op;
    logic [31:0] rs1, rs2, imm, pc, a, b;
    logic [4:0]  rd;
    logic        apc, bimm, rdw;
    out_t        e;

    vecs[0]  = '{4'd0,  32'h0000_0005, 32'h0,         32'hFFFF_FFFF, 32'h0000_0100, 1'b0, 1'b1, 32'h0000_0004};
    vecs[1]  = '{4'd7,  32'h8000_0000, 32'h0000_0024, 32'h0,         32'h0000_0104, 1'b0, 1'b0, 32'hF800_0000};
    vecs[2]  = '{4'd3,  32'h8000_0000, 32'h0000_0001, 32'h0,         32'h0000_0108, 1'b0, 1'b0, 32'h0000_0001};
    vecs[3]  = '{4'd4,  32'h8000_0000, 32'h0000_0001, 32'h0,         32'h0000_010C, 1'b0, 1'b0, 32'h0000_0000};
    vecs[4]  = '{4'd1,  32'h0000_0000, 32'h0000_0001, 32'h0,         32'h0000_0110, 1'b0, 1'b0, 32'hFFFF_FFFF};
    vecs[5]  = '{4'd2,  32'h0000_0001, 32'h0000_003F, 32'h0,         32'h0000_0114, 1'b0, 1'b0, 32'h8000_0000};
    vecs[6]  = '{4'd6,  32'h8000_0000, 32'h0000_0021, 32'h0,         32'h0000_0118, 1'b0, 1'b0, 32'h4000_0000};
    vecs[7]  = '{4'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,         32'h0000_011C, 1'b0, 1'b0, 32'h0FF0_0FF0};
    vecs[8]  = '{4'd8,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0,         32'h0000_0120, 1'b0, 1'b0, 32'hFFFF_F0F0};
    vecs[9]  = '{4'd9,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,         32'h0000_0124, 1'b0, 1'b0, 32'hF000_F000};
    vecs[10] = '{4'd10, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0,         32'h0000_0128, 1'b0, 1'b0, 32'h1234_5678};
    vecs[11] = '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0000_012C, 1'b0, 1'b0, 32'h0000_0000};
    vecs[12] = '{4'd0,  32'hAAAA_AAAA, 32'h0,         32'h0000_0004, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_1004};
    vecs[13] = '{4'd3,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0,         32'h0000_0130, 1'b0, 1'b0, 32'h0000_0001};
    vecs[14] = '{4'd4,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0,         32'h0000_0134, 1'b0, 1'b0, 32'h0000_0000};

    rst_i   = 1'b1;
    flush_i = 1'b0;
    drive(1'b0, 4'd0, '0, '0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0);
    #3;
    check("reset_valid",  {31'b0, execute_v_o}, 32'd0);
    check("reset_stall",  {31'b0, stall_o}, 32'd0);
    check("reset_pc",     execute_pc, 32'd0);
    check("reset_rd",     {27'b0, execute_rd}, 32'd0);
    check("reset_rdw",    {31'b0, execute_rd_w_v}, 32'd0);
    check("reset_result", execute_result, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Single-cycle table, issued back to back.
    for (int i = 0; i < 15; i++) begin
      present(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].pc,
              5'(i + 1), vecs[i].a_pc, vecs[i].b_imm, 1'(i % 2));
      check($sformatf("vec%0d_valid", i), {31'b0, execute_v_o}, 32'd1);
      check($sformatf("vec%0d_result", i), execute_result, vecs[i].exp);
      check($sformatf("vec%0d_pc", i), execute_pc, vecs[i].pc);
      check($sformatf("vec%0d_rd", i), {27'b0, execute_rd}, 32'(i + 1));
      check($sformatf("vec%0d_rdw", i), {31'b0, execute_rd_w_v}, 32'(i % 2));
    end
    idle(1);
    check("idle_valid_low", {31'b0, execute_v_o}, 32'd0);

    run_long("mul",        4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_long("mulhu",      4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_long("divu",       4'd13, 32'd100, 32'd7, 32'd14);
    run_long("remu",       4'd14, 32'd100, 32'd7, 32'd2);
    run_long("divu_by0",   4'd13, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
    run_long("remu_by0",   4'd14, 32'h0000_1234, 32'd0, 32'h0000_1234);

    // MUL immediately followed by a held MULHU.
    mon_q.delete();
    present(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0000_3000, 5'd3, 1'b0, 1'b0, 1'b1);
    present(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0000_3004, 5'd4, 1'b0, 1'b0, 1'b1);
    idle(40);
    check("b2b_count", mon_q.size(), 32'd2);
    if (mon_q.size() >= 2) begin
      check("b2b_mul", mon_q[0].result, 32'h0000_0001);
      check("b2b_mulhu", mon_q[1].result, 32'hFFFF_FFFE);
      check("b2b_spacing", mon_q[1].cyc - mon_q[0].cyc, 32'd33);
    end

    // ADD held behind DIVU.
    mon_q.delete();
    present(4'd13, 32'd100, 32'd7, 32'h0, 32'h0000_4000, 5'd5, 1'b0, 1'b0, 1'b1);
    present(4'd0, 32'd3, 32'd4, 32'h0, 32'h0000_4004, 5'd6, 1'b0, 1'b0, 1'b1);
    idle(5);
    check("held_count", mon_q.size(), 32'd2);
    if (mon_q.size() >= 2) begin
      check("held_div", mon_q[0].result, 32'd14);
      check("held_add", mon_q[1].result, 32'd7);
      check("held_add_rd", {27'b0, mon_q[1].rd}, 32'd6);
      check("held_spacing", mon_q[1].cyc - mon_q[0].cyc, 32'd1);
    end

    // Flush at counter = 10.
    mon_q.delete();
    present(4'd13, 32'd1000, 32'd3, 32'h0, 32'h0000_5000, 5'd8, 1'b0, 1'b0, 1'b1);
    idle(10);
    check("flush_pre_stall", {31'b0, stall_o}, 32'd1);
    flush_i = 1'b1;
    idle(1);
    flush_i = 1'b0;
    check("flush_stall", {31'b0, stall_o}, 32'd0);
    check("flush_valid", {31'b0, execute_v_o}, 32'd0);
    idle(40);
    check("flush_no_output", mon_q.size(), 32'd0);

    // Asynchronous reset in the middle of a multiply.
    present(4'd0, 32'h1111_0000, 32'h0000_2222, 32'h0, 32'h0000_0500, 5'd9, 1'b0, 1'b0, 1'b1);
    present(4'd11, 32'd5, 32'd6, 32'h0, 32'h0000_0600, 5'd10, 1'b0, 1'b0, 1'b1);
    idle(5);
    check("prereset_stall", {31'b0, stall_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    check("areset_stall",  {31'b0, stall_o}, 32'd0);
    check("areset_valid",  {31'b0, execute_v_o}, 32'd0);
    check("areset_pc",     execute_pc, 32'd0);
    check("areset_rd",     {27'b0, execute_rd}, 32'd0);
    check("areset_result", execute_result, 32'd0);
    #2;
    rst_i = 1'b0;
    idle(2);

    // Random instruction stream against the reference model.
    mon_q.delete();
    exp_q.delete();
    for (int k = 0; k < 80; k++) begin
      op   = 4'($urandom_range(0, 15));
      rs1  = $urandom;
      rs2  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      imm  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      pc   = $urandom & 32'hFFFF_FFFC;
      rd   = 5'($urandom_range(0, 31));
      apc  = 1'($urandom_range(0, 1));
      bimm = 1'($urandom_range(0, 1));
      rdw  = 1'($urandom_range(0, 1));
      a    = apc ? pc : rs1;
      b    = bimm ? imm : rs2;
      e.result = ref_result(op, a, b);
      e.pc     = pc;
      e.rd     = rd;
      e.rdw    = rdw;
      e.cyc    = 0;
      exp_q.push_back(e);
      present(op, rs1, rs2, imm, pc, rd, apc, bimm, rdw);
      idle($urandom_range(0, 2));
    end
    idle(40);
    check("rand_count", mon_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < mon_q.size(); k++) begin
      check($sformatf("rand%0d_result", k), mon_q[k].result, exp_q[k].result);
      check($sformatf("rand%0d_pc", k), mon_q[k].pc, exp_q[k].pc);
      check($sformatf("rand%0d_rd", k), {27'b0, mon_q[k].rd}, {27'b0, exp_q[k].rd});
      check($sformatf("rand%0d_rdw", k), {31'b0, mon_q[k].rdw}, {31'b0, exp_q[k].rdw});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the rvga pipeline, sitting directly downstream of the register-fetch stage. It consumes that stage's PC, destination register, operand data and immediate plus a decoded execute opcode, and produces a registered result for the memory/writeback path. Single-cycle integer ALU operations complete in one cycle. Unsigned multiply and divide run on an iterative 32-cycle unit that back-pressures upstream through `stall_o`.

## Interface
Parameters:
- `width_p`, default 32: datapath width, equal to `$bits(rvga_word)`. Only 32 is supported.
- `iter_p`, default 32: mul/div iteration count. It must equal `width_p`.

Ports:
- `clk_i` in 1: clock. The block has one clock domain; all state updates on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `flush_i` in 1: synchronous kill of in-flight and incoming work.
- `rfetch_v_i` in 1: input instruction valid.
- `rfetch_pc` in 32: instruction PC.
- `rfetch_rd` in 5: destination register.
- `rfetch_rs1_data` in 32: rs1 operand.
- `rfetch_rs2_data` in 32: rs2 operand.
- `rfetch_imm_data` in 32: immediate.
- `exec_op_i` in 4: opcode.
- `exec_a_pc_i` in 1: operand A selects `rfetch_pc` instead of rs1.
- `exec_b_imm_i` in 1: operand B selects immediate instead of rs2.
- `exec_rd_w_v_i` in 1: instruction writes rd.
- `stall_o` out 1: upstream must hold its outputs this cycle.
- `execute_v_o` out 1: output valid.
- `execute_pc` out 32: registered PC.
- `execute_rd` out 5: registered destination register.
- `execute_rd_w_v` out 1: registered rd write enable, qualified by valid.
- `execute_result` out 32: registered result.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU.
  - 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 PASSB (result = B).
  - 11 MUL (low 32 bits), 12 MULHU (high 32 bits of unsigned product).
  - 13 DIVU, 14 REMU.
  - 15 reserved: result 0, otherwise treated as single-cycle.
- Arithmetic rules:
  - Shift amount is B[4:0].
  - ADD/SUB wrap modulo 2^32.
  - SLT/SLTU produce 0 or 1.
- Divide by zero: DIVU returns 0xFFFFFFFF; REMU returns the dividend (A). These still take the full iteration count.
- FSM states:
  - IDLE to BUSY when `rfetch_v_i` is high, the opcode is 11–14, and `flush_i` is low.
  - BUSY to IDLE when the iteration counter reaches `iter_p`-1, or on `flush_i`.
- Operand capture on entry to BUSY: A, B, op, pc, rd and `rd_w_v` are captured into internal registers, and the counter clears to 0.
- Iteration algorithms:
  - MUL/MULHU use shift-add with a 64-bit accumulator, one multiplier bit per cycle.
  - DIVU/REMU use restoring division, one quotient bit per cycle.
- `stall_o` = (state == BUSY). It is combinational from the state register.
- Acceptance: an input is accepted on any edge where `rfetch_v_i` is high, `stall_o` is low and `flush_i` is low. While stalled, the held upstream instruction is not consumed.
- Single-cycle accept: output registers load pc/rd/`rd_w_v`/result and `execute_v_o` <= 1.
- Mul/div accept: `execute_v_o` <= 0 on that edge and on every BUSY edge except the final one. The final BUSY edge loads the result and the captured pc/rd/`rd_w_v`, and sets `execute_v_o` <= 1.
- No accept and not finishing: `execute_v_o` <= 0. The other output registers hold their values.
- `execute_rd_w_v` is registered as `exec_rd_w_v_i` AND accept.
- `flush_i` takes priority over everything:
  - state <= IDLE and `execute_v_o` <= 0.
  - The in-flight mul/div is discarded and nothing is accepted that edge.

## Timing
- Reset (async assert, released synchronously by the parent):
  - state = IDLE, counter = 0.
  - `stall_o` = 0, `execute_v_o` = 0.
  - `execute_pc`, `execute_rd`, `execute_rd_w_v`, `execute_result` = 0.
- Reset asserted mid-BUSY aborts the operation immediately, without waiting for a clock edge.
- Single-cycle op accepted at edge N: output valid during cycle N..N+1. Throughput is one per cycle back-to-back.
- Mul/div accepted at edge N:
  - `stall_o` high from after edge N until edge N+32.
  - Result valid during cycle N+32..N+33.
  - An instruction held upstream is accepted at edge N+33 at the earliest.
- A mul/div immediately followed by a mul/div gives results 33 cycles apart.
- `flush_i` during BUSY: `stall_o` is low in the cycle after the flush edge.

## Test plan
- ADD with immediate: rs1 = 0x00000005, imm = 0xFFFFFFFF, `exec_b_imm_i` = 1 -> `execute_result` = 0x00000004 one cycle later, `execute_v_o` = 1.
- SRA: A = 0x80000000, B = 0x00000024 -> result 0xF8000000 (shift amount 4). Same operands with SLT, A = 0x80000000, B = 1 -> result 1.
- MUL then MULHU, each with A = B = 0xFFFFFFFF:
  - MUL -> 0x00000001.
  - MULHU -> 0xFFFFFFFE.
  - `stall_o` high for exactly 32 cycles per operation.
  - Results 33 cycles apart.
- DIVU/REMU:
  - A = 100, B = 7 -> 14 / 2.
  - A = 0x1234, B = 0 -> 0xFFFFFFFF / 0x1234.
  - Latency 32 in all four cases.
- ADD held behind DIVU: the ADD is presented and held during the stall, is accepted exactly once, its result appears the cycle after the DIVU result, and there are no duplicate valids.
- `flush_i` asserted at BUSY counter = 10 -> no valid output from that op and `stall_o` low next cycle. Separately, `rst_i` asserted mid-BUSY asynchronously clears all outputs to 0.
